fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the pipelined CPU: holds the program counter, fetches through a variable-latency instruction-memory request/acknowledge port and fills the IF/ID pipeline register. It consumes the next-PC selected by the PC multiplexer (`addr_i`) and produces `pc_o`, which drives the PC+4 adder and the branch-target adder feeding that multiplexer. It handles load-use stalls from the hazard unit and branch flushes, including a flush that arrives while a memory request is still outstanding.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded on reset
- `NOP_INSTR`, 32'h0000_0013: instruction word placed in IF/ID for a bubble
- `clk_i` in 1: clock, all state on rising edge
- `rst_i` in 1: reset, asynchronous, active-low
- `addr_i` in 32: next PC from the PC multiplexer
- `stall_i` in 1: hazard unit, hold IF/ID and PC
- `flush_i` in 1: branch taken, squash IF/ID, redirect to `addr_i`
- `pc_o` out 32: PC of the instruction currently being fetched
- `imem_req_o` out 1: memory request valid
- `imem_addr_o` out 32: request address
- `imem_ack_i` in 1: memory response valid; may be high in the same cycle as the request
- `imem_data_i` in 32: instruction word, valid with `imem_ack_i`
- `ifid_valid_o` out 1: IF/ID holds a real instruction
- `ifid_pc_o` out 32: IF/ID PC
- `ifid_instr_o` out 32: IF/ID instruction

## Operation
- States: IDLE, FETCH, HOLD. Reset forces IDLE, `pc_o`=RESET_PC, `imem_req_o`=0, `imem_addr_o`=RESET_PC, IF/ID = {valid 0, pc 0, NOP_INSTR}, redirect flag clear.
- IDLE → FETCH unconditionally on the first edge after reset release.
- FETCH: `imem_req_o`=1 and `imem_addr_o`=`pc_o`. Once issued, a request is never withdrawn; `imem_addr_o` stays stable until `imem_ack_i`.
- Priority per edge: flush > stall > normal.
- FETCH, ack, no stall, no flush: IF/ID ← {1, `pc_o`, `imem_data_i`}; `pc_o` ← `addr_i`; stay in FETCH.
- FETCH, ack, stall: capture the word in the hold buffer; IF/ID unchanged; go to HOLD; `pc_o` unchanged.
- FETCH, no ack, no stall: IF/ID ← bubble {0, 0, NOP_INSTR}.
- FETCH, no ack, stall: IF/ID unchanged.
- HOLD: `imem_req_o`=0. When stall drops, IF/ID ← buffer; `pc_o` ← `addr_i`; go to FETCH.
- Flush with ack in the same cycle, or in HOLD: discard the word or buffer; IF/ID ← bubble; `pc_o` ← `addr_i`; go to FETCH.
- Flush in FETCH without ack: IF/ID ← bubble; redirect_q ← `addr_i`; set redirect flag.
  - A later flush before the ack overwrites redirect_q.
  - On the ack, the data is discarded and IF/ID ← bubble. `pc_o` ← redirect_q and the flag clears, ignoring `addr_i` and `stall_i` in that cycle.
- A redirect-pending ack never loads IF/ID with the stale word.
- PC arithmetic lives upstream. `pc_o` is taken verbatim from `addr_i`; there is no alignment check and 32-bit wrap is passed through.

## Timing
- Reset is asynchronous assert and synchronous release. An assertion mid-request abandons it: `imem_req_o` drops immediately, and a late ack is ignored because the block is in IDLE.
- First request is visible one cycle after reset release.
- Zero-wait memory (ack tied high) gives one instruction per cycle. IF/ID is valid for an address A one edge after `pc_o`=A.
- An N-cycle memory latency produces N bubbles in IF/ID.
- All outputs are registered except `imem_req_o`, which is decoded from state.

## Structure
- Shared header `cpu_defs.vh`: state encodings, NOP_INSTR, RESET_PC default.
- Sub-module `ifid_reg`: 65-bit register with asynchronous active-low reset, load enable and bubble-insert control. The control FSM stays in `fetch_unit`.

## Test plan
- Reset release with ack tied 1 and `addr_i`=`pc_o`+4: `pc_o` 0,4,8,…; `ifid_pc_o` trails by one cycle; `ifid_valid_o`=1 from the second edge.
- Ack delayed 3 cycles at PC 0x10: `imem_addr_o` holds 0x10 for all 4 cycles; 3 bubbles; then IF/ID={1,0x10,data}.
- Stall 2 cycles coincident with the ack at PC 0x20: IF/ID holds its prior contents, HOLD entered, `imem_req_o`=0. Stall drop loads 0x20's word, and the next request goes to `addr_i`.
- Flush with `addr_i`=0x80 while the request to 0x24 is pending, ack 2 cycles later: bubble, 0x24 data discarded, then `imem_addr_o`=0x80.
- Flush and stall in the same cycle with ack: flush wins, bubble inserted, `pc_o`=`addr_i`.
- Reset asserted mid-request: all outputs return to reset values asynchronously; the late ack has no effect.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encodings
// and the default reset PC / bubble instruction word.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

    // addi x0, x0, 0 -- the canonical RISC-V NOP used for bubbles
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_ifid_reg.sv
// IF/ID pipeline register: {valid, pc, instr} with load enable and a
// bubble-insert control that takes precedence over load.
module ifid_reg
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        bubble_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o
);

    logic        valid_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;

    // Bubble overrides load; with neither asserted the register holds.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= 1'b0;
            pc_q    <= 32'h0;
            instr_q <= NOP_INSTR;
        end else if (bubble_i) begin
            valid_q <= 1'b0;
            pc_q    <= 32'h0;
            instr_q <= NOP_INSTR;
        end else if (load_i) begin
            valid_q <= 1'b1;
            pc_q    <= pc_i;
            instr_q <= instr_i;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues requests on a variable-latency
// req/ack instruction-memory port and fills the IF/ID register. Handles
// load-use stalls (hold buffer) and branch flushes, including a flush that
// lands while a request is still outstanding (deferred redirect).
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] addr_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic [31:0] pc_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic        ifid_valid_o,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_instr_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  redir_pc_q, redir_pc_d;
    logic         redir_vld_q, redir_vld_d;
    logic [31:0]  hold_q, hold_d;

    logic         ifid_load;
    logic         ifid_bubble;
    logic [31:0]  ifid_instr;

    // Next-state and IF/ID control decode; priority is flush > stall > normal.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        redir_pc_d  = redir_pc_q;
        redir_vld_d = redir_vld_q;
        hold_d      = hold_q;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        ifid_instr  = imem_data_i;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                if (flush_i) begin
                    ifid_bubble = 1'b1;
                    if (imem_ack_i) begin
                        // Request completes now: drop the word, redirect at once.
                        pc_d        = addr_i;
                        redir_vld_d = 1'b0;
                    end else begin
                        // Request cannot be withdrawn; remember where to go.
                        redir_pc_d  = addr_i;
                        redir_vld_d = 1'b1;
                    end
                end else if (redir_vld_q) begin
                    // Outstanding request belongs to the squashed path.
                    if (imem_ack_i) begin
                        ifid_bubble = 1'b1;
                        pc_d        = redir_pc_q;
                        redir_vld_d = 1'b0;
                    end else if (!stall_i) begin
                        ifid_bubble = 1'b1;
                    end
                end else if (stall_i) begin
                    if (imem_ack_i) begin
                        hold_d  = imem_data_i;
                        state_d = ST_HOLD;
                    end
                end else if (imem_ack_i) begin
                    ifid_load = 1'b1;
                    pc_d      = addr_i;
                end else begin
                    ifid_bubble = 1'b1;
                end
            end

            ST_HOLD: begin
                if (flush_i) begin
                    ifid_bubble = 1'b1;
                    pc_d        = addr_i;
                    state_d     = ST_FETCH;
                end else if (!stall_i) begin
                    ifid_load  = 1'b1;
                    ifid_instr = hold_q;
                    pc_d       = addr_i;
                    state_d    = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state; reset abandons any outstanding request.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            redir_pc_q  <= RESET_PC;
            redir_vld_q <= 1'b0;
            hold_q      <= NOP_INSTR;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            redir_pc_q  <= redir_pc_d;
            redir_vld_q <= redir_vld_d;
            hold_q      <= hold_d;
        end
    end

    ifid_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid_reg (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (ifid_load),
        .bubble_i (ifid_bubble),
        .pc_i     (pc_q),
        .instr_i  (ifid_instr),
        .valid_o  (ifid_valid_o),
        .pc_o     (ifid_pc_o),
        .instr_o  (ifid_instr_o)
    );

    // The PC only moves on an ack or on leaving HOLD, so the request address
    // is stable for the whole life of a request.
    assign pc_o        = pc_q;
    assign imem_addr_o = pc_q;
    assign imem_req_o  = (state_q == ST_FETCH);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a vector table walks one continuous program
// flow through zero-wait fetch, wait states, stall/hold, deferred and
// immediate flushes and PC wrap; hand sequences cover reset mid-request.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic        stall;
    logic        flush;
    logic [31:0] pc;
    logic        req;
    logic [31:0] iaddr;
    logic        ack;
    logic [31:0] data;
    logic        ivalid;
    logic [31:0] ipc;
    logic [31:0] iinstr;

    int checks;
    int failures;

    fetch_unit dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .addr_i       (addr),
        .stall_i      (stall),
        .flush_i      (flush),
        .pc_o         (pc),
        .imem_req_o   (req),
        .imem_addr_o  (iaddr),
        .imem_ack_i   (ack),
        .imem_data_i  (data),
        .ifid_valid_o (ivalid),
        .ifid_pc_o    (ipc),
        .ifid_instr_o (iinstr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic        f;
        logic        a;
        logic [31:0] ad;
        logic [31:0] d;
        logic [31:0] e_pc;
        logic        e_req;
        logic        e_v;
        logic [31:0] e_ipc;
        logic [31:0] e_ins;
    } vec_t;

    vec_t vecs[29];

    // Instruction word the memory model returns for address a.
    function automatic logic [31:0] dw(input logic [31:0] a);
        return ~a;
    endfunction

    function automatic vec_t mk(input logic s, input logic f, input logic a,
                                input logic [31:0] ad, input logic [31:0] d,
                                input logic [31:0] e_pc, input logic e_req,
                                input logic e_v, input logic [31:0] e_ipc,
                                input logic [31:0] e_ins);
        vec_t v;
        v.s = s; v.f = f; v.a = a; v.ad = ad; v.d = d;
        v.e_pc = e_pc; v.e_req = e_req; v.e_v = e_v; v.e_ipc = e_ipc; v.e_ins = e_ins;
        return v;
    endfunction

    // Compares {pc, req, imem_addr, ifid_valid, ifid_pc, ifid_instr}.
    task automatic check(input string name, input logic [31:0] e_pc, input logic e_req,
                         input logic e_v, input logic [31:0] e_ipc, input logic [31:0] e_ins);
        logic [129:0] act;
        logic [129:0] exp;
        act = {pc, req, iaddr, ivalid, ipc, iinstr};
        exp = {e_pc, e_req, e_pc, e_v, e_ipc, e_ins};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got pc=%h req=%b addr=%h v=%b ipc=%h ins=%h want pc=%h req=%b addr=%h v=%b ipc=%h ins=%h",
                     name, pc, req, iaddr, ivalid, ipc, iinstr,
                     e_pc, e_req, e_pc, e_v, e_ipc, e_ins);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst   = 1'b0;
        addr  = 32'h0;
        stall = 1'b0;
        flush = 1'b0;
        ack   = 1'b0;
        data  = 32'h0;

        //            s  f  a  addr          data               pc            req v  ipc           instr
        vecs[0]  = mk(0, 0, 1, 32'h4,        dw(32'h0),         32'h0,        1, 0, 32'h0,        NOP);
        vecs[1]  = mk(0, 0, 1, 32'h4,        dw(32'h0),         32'h4,        1, 1, 32'h0,        dw(32'h0));
        vecs[2]  = mk(0, 0, 1, 32'h8,        dw(32'h4),         32'h8,        1, 1, 32'h4,        dw(32'h4));
        vecs[3]  = mk(0, 0, 1, 32'h10,       dw(32'h8),         32'h10,       1, 1, 32'h8,        dw(32'h8));
        vecs[4]  = mk(0, 0, 0, 32'h14,       32'h0,             32'h10,       1, 0, 32'h0,        NOP);
        vecs[5]  = mk(0, 0, 0, 32'h14,       32'h0,             32'h10,       1, 0, 32'h0,        NOP);
        vecs[6]  = mk(0, 0, 0, 32'h14,       32'h0,             32'h10,       1, 0, 32'h0,        NOP);
        vecs[7]  = mk(0, 0, 1, 32'h20,       dw(32'h10),        32'h20,       1, 1, 32'h10,       dw(32'h10));
        vecs[8]  = mk(1, 0, 1, 32'h24,       dw(32'h20),        32'h20,       0, 1, 32'h10,       dw(32'h10));
        vecs[9]  = mk(1, 0, 0, 32'h24,       32'h0,             32'h20,       0, 1, 32'h10,       dw(32'h10));
        vecs[10] = mk(0, 0, 0, 32'h24,       32'h0,             32'h24,       1, 1, 32'h20,       dw(32'h20));
        vecs[11] = mk(0, 1, 0, 32'h80,       32'h0,             32'h24,       1, 0, 32'h0,        NOP);
        vecs[12] = mk(0, 0, 0, 32'h28,       32'h0,             32'h24,       1, 0, 32'h0,        NOP);
        vecs[13] = mk(1, 0, 1, 32'h28,       dw(32'h24),        32'h80,       1, 0, 32'h0,        NOP);
        vecs[14] = mk(0, 0, 1, 32'h84,       dw(32'h80),        32'h84,       1, 1, 32'h80,       dw(32'h80));
        vecs[15] = mk(0, 1, 0, 32'h100,      32'h0,             32'h84,       1, 0, 32'h0,        NOP);
        vecs[16] = mk(0, 1, 0, 32'h200,      32'h0,             32'h84,       1, 0, 32'h0,        NOP);
        vecs[17] = mk(0, 0, 1, 32'h88,       dw(32'h84),        32'h200,      1, 0, 32'h0,        NOP);
        vecs[18] = mk(0, 0, 1, 32'h204,      dw(32'h200),       32'h204,      1, 1, 32'h200,      dw(32'h200));
        vecs[19] = mk(1, 1, 1, 32'h300,      dw(32'h204),       32'h300,      1, 0, 32'h0,        NOP);
        vecs[20] = mk(0, 0, 1, 32'h304,      dw(32'h300),       32'h304,      1, 1, 32'h300,      dw(32'h300));
        vecs[21] = mk(1, 0, 1, 32'h308,      dw(32'h304),       32'h304,      0, 1, 32'h300,      dw(32'h300));
        vecs[22] = mk(1, 1, 0, 32'h400,      32'h0,             32'h400,      1, 0, 32'h0,        NOP);
        vecs[23] = mk(0, 0, 1, 32'h404,      dw(32'h400),       32'h404,      1, 1, 32'h400,      dw(32'h400));
        vecs[24] = mk(1, 0, 0, 32'h408,      32'h0,             32'h404,      1, 1, 32'h400,      dw(32'h400));
        vecs[25] = mk(0, 0, 1, 32'h408,      dw(32'h404),       32'h408,      1, 1, 32'h404,      dw(32'h404));
        vecs[26] = mk(0, 0, 1, 32'hFFFF_FFFC, dw(32'h408),      32'hFFFF_FFFC, 1, 1, 32'h408,     dw(32'h408));
        vecs[27] = mk(0, 0, 1, 32'h0,        dw(32'hFFFF_FFFC), 32'h0,        1, 1, 32'hFFFF_FFFC, dw(32'hFFFF_FFFC));
        vecs[28] = mk(0, 0, 1, 32'h3,        dw(32'h0),         32'h3,        1, 1, 32'h0,        dw(32'h0));

        repeat (2) @(posedge clk);
        #1;
        check("reset_values", 32'h0, 1'b0, 1'b0, 32'h0, NOP);

        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 29; i++) begin
            stall = vecs[i].s;
            flush = vecs[i].f;
            ack   = vecs[i].a;
            addr  = vecs[i].ad;
            data  = vecs[i].d;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_req,
                  vecs[i].e_v, vecs[i].e_ipc, vecs[i].e_ins);
        end

        // Reset asserted mid-request, between edges.
        stall = 1'b0;
        flush = 1'b0;
        ack   = 1'b0;
        addr  = 32'h50;
        #2;
        rst = 1'b0;
        #1;
        check("async_reset", 32'h0, 1'b0, 1'b0, 32'h0, NOP);

        // Late ack while still in reset.
        ack  = 1'b1;
        data = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        check("ack_in_reset", 32'h0, 1'b0, 1'b0, 32'h0, NOP);

        // Release; the ack on the first edge lands in IDLE and is ignored.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("late_ack_idle", 32'h0, 1'b1, 1'b0, 32'h0, NOP);

        // Normal fetch resumes from RESET_PC.
        addr = 32'h4;
        data = dw(32'h0);
        @(posedge clk);
        #1;
        check("refetch_0", 32'h4, 1'b1, 1'b1, 32'h0, dw(32'h0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
